// File: rtl/wb_chk_pkg.sv
// Shared types, constants and pattern helper for the Wishbone memory checker.
package wb_chk_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned IDX_W      = 16;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADR_W      = 32;
    localparam int unsigned ERR_W      = 16;
    localparam int unsigned WDOG_W     = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        GAP   = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } chk_state_t;

    // Test pattern for word index: zero-extended index XOR seed mask.
    function automatic logic [DATA_W-1:0] pat(input logic [IDX_W-1:0] index,
                                              input logic [DATA_W-1:0] seed);
        return {16'h0, index} ^ seed;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle; master drives request fields, slave returns data and ack.
interface wshb_if (
    input logic clk
);
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (
        input  dat_sm, ack,
        output adr, dat_ms, we, sel, stb, cyc, cti, bte
    );

    modport slave (
        input  clk, adr, dat_ms, we, sel, stb, cyc, cti, bte,
        output dat_sm, ack
    );
endinterface

// File: rtl/wb_chk_watchdog.sv
// Counts consecutive stalled strobe cycles; flags expiry on the cycle the limit is reached.
module wb_chk_watchdog
    import wb_chk_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    logic [WDOG_W-1:0] count;

    // Expiry is combinational so the master can abort on the very edge the count hits the limit.
    assign expired = run && !clr && (count == WDOG_W'(TIMEOUT - 1));

    // Stall counter: restarts whenever the stall streak breaks, holds once expired.
    always_ff @(posedge clk) begin
        if (rst || clr || !run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + WDOG_W'(1);
        end
    end

endmodule

// File: rtl/wb_mem_checker.sv
// Wishbone classic master: writes an address-derived pattern, reads it back and tallies mismatches.
module wb_mem_checker
    import wb_chk_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h0000_0000,
    parameter int unsigned N_WORDS  = 2048,
    parameter logic [31:0] SEED     = 32'hA5A5_5A5A,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADR_W-1:0]  first_err_adr,
    wshb_if.master            wb_m
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    chk_state_t         state;
    logic [IDX_W-1:0]   index;
    logic [IDX_W-1:0]   next_idx;
    logic [ADR_W-1:0]   adr;
    logic [DATA_W-1:0]  dat_ms;
    logic               we;
    logic               stb;
    logic               cyc;
    logic               ack_c;
    logic               mismatch_c;
    logic [ERR_W-1:0]   err_inc_c;
    logic               expired;

    // Byte address of a word index, wrapping modulo 2^32.
    function automatic logic [ADR_W-1:0] addr_of(input logic [IDX_W-1:0] i);
        return BASE_ADR + (ADR_W'(i) * ADR_W'(WORD_BYTES));
    endfunction

    assign wb_m.adr    = adr;
    assign wb_m.dat_ms = dat_ms;
    assign wb_m.we     = we;
    assign wb_m.stb    = stb;
    assign wb_m.cyc    = cyc;
    assign wb_m.sel    = 4'hF;
    assign wb_m.cti    = 3'b000;
    assign wb_m.bte    = 2'b00;

    // Ack only counts while our own cycle and strobe are asserted.
    assign ack_c      = cyc && stb && wb_m.ack;
    assign next_idx   = index + IDX_W'(1);
    assign mismatch_c = (wb_m.dat_sm != pat(index, SEED));
    assign err_inc_c  = (err_count == '1) ? err_count : err_count + ERR_W'(1);

    wb_chk_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     ((state == GAP) || !cyc),
        .run     (stb && !wb_m.ack),
        .expired (expired)
    );

    // Run sequencer: launch, write sweep, one idle gap, read-compare sweep, result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            index         <= '0;
            adr           <= '0;
            dat_ms        <= '0;
            we            <= 1'b0;
            stb           <= 1'b0;
            cyc           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_adr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= WRITE;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        timeout       <= 1'b0;
                        err_count     <= '0;
                        first_err_adr <= '0;
                        index         <= '0;
                        cyc           <= 1'b1;
                        stb           <= 1'b1;
                        we            <= 1'b1;
                        adr           <= addr_of('0);
                        dat_ms        <= pat('0, SEED);
                    end
                end

                WRITE: begin
                    if (expired) begin
                        state   <= DONE;
                        cyc     <= 1'b0;
                        stb     <= 1'b0;
                        we      <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end else if (ack_c) begin
                        if (index == LAST_IDX) begin
                            state <= GAP;
                            cyc   <= 1'b0;
                            stb   <= 1'b0;
                            we    <= 1'b0;
                            index <= '0;
                        end else begin
                            index  <= next_idx;
                            adr    <= addr_of(next_idx);
                            dat_ms <= pat(next_idx, SEED);
                        end
                    end
                end

                GAP: begin
                    state <= READ;
                    index <= '0;
                    cyc   <= 1'b1;
                    stb   <= 1'b1;
                    we    <= 1'b0;
                    adr   <= addr_of('0);
                end

                READ: begin
                    if (expired) begin
                        state   <= DONE;
                        cyc     <= 1'b0;
                        stb     <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end else if (ack_c) begin
                        if (mismatch_c) begin
                            err_count <= err_inc_c;
                            if (err_count == '0) begin
                                first_err_adr <= adr;
                            end
                        end
                        if (index == LAST_IDX) begin
                            state <= DONE;
                            cyc   <= 1'b0;
                            stb   <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !mismatch_c && (err_count == '0) && !timeout;
                        end else begin
                            index <= next_idx;
                            adr   <= addr_of(next_idx);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    cyc   <= 1'b0;
                    stb   <= 1'b0;
                    we    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_checker.sv
// Bench for wb_mem_checker: configurable memory slave plus transfer and result scoreboards.
module tb_wb_mem_checker;

    localparam int unsigned N   = 16;
    localparam logic [31:0] SD  = 32'h0000_0000;
    localparam int unsigned TMO = 10;
    localparam logic [31:0] BA  = 32'h0000_0000;
    localparam int          LIMIT = 2000;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    typedef struct {
        logic        pass;
        logic        tmo;
        logic [15:0] errs;
        logic [31:0] first;
        int          cycles;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] first_err_adr;

    wshb_if bus (.clk(clk));

    wb_mem_checker #(
        .BASE_ADR (BA),
        .N_WORDS  (N),
        .SEED     (SD),
        .TIMEOUT  (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_count     (err_count),
        .first_err_adr (first_err_adr),
        .wb_m          (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    xfer_t exp_q[$];
    res_t  res_q[$];

    // Slave behaviour knobs.
    int          wait_states = 0;
    bit          stuck3      = 1'b0;
    bit          hang_en     = 1'b0;
    logic [31:0] hang_adr    = 32'h0000_000C;
    int          wcnt;
    logic [31:0] mem [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Slave: ack after wait_states stalls, never at the hang address, bit 3 optionally stuck low.
    always_comb begin
        bus.ack    = 1'b0;
        bus.dat_sm = mem[bus.adr[5:2]] & (stuck3 ? 32'hFFFF_FFF7 : 32'hFFFF_FFFF);
        if (bus.cyc && bus.stb && !(hang_en && bus.adr == hang_adr) && wcnt == wait_states)
            bus.ack = 1'b1;
    end

    // Wait-state counter, restarted by each completed or dropped transfer.
    always @(posedge clk) begin
        if (!(bus.cyc && bus.stb) || bus.ack) wcnt <= 0;
        else                                  wcnt <= wcnt + 1;
    end

    // Transfer monitor: every acked transfer is matched against the expected sequence.
    always @(negedge clk) begin
        xfer_t e;
        if (bus.cyc && bus.stb && bus.ack) begin
            if (exp_q.size() == 0) begin
                check("xfer_extra", bus.adr, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("xfer_we", 32'(bus.we), 32'(e.we));
                check("xfer_adr", bus.adr, e.adr);
                if (e.we) check("xfer_dat", bus.dat_ms, e.dat);
            end
            if (bus.we) mem[bus.adr[5:2]] = bus.dat_ms;
        end
    end

    function automatic logic [31:0] model_pat(input int i);
        logic [31:0] v;
        v = 32'(i) & 32'h0000_FFFF;
        return v ^ SD;
    endfunction

    // Push expected transfers and final result for one run.
    task automatic push_run(input bit is_stuck, input bit hang, input int hang_idx, input int ws);
        res_t r;
        xfer_t x;
        int nw;
        r.pass = 1'b1; r.tmo = 1'b0; r.errs = 16'd0; r.first = 32'd0;
        nw = hang ? hang_idx : int'(N);
        for (int i = 0; i < nw; i++) begin
            x.we = 1'b1; x.adr = BA + 32'(4 * i); x.dat = model_pat(i);
            exp_q.push_back(x);
        end
        if (hang) begin
            r.pass = 1'b0; r.tmo = 1'b1;
            r.cycles = hang_idx * (ws + 1) + int'(TMO);
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                x.we = 1'b0; x.adr = BA + 32'(4 * i); x.dat = 32'd0;
                exp_q.push_back(x);
                if (is_stuck && model_pat(i)[3]) begin
                    if (r.errs == 16'd0) r.first = BA + 32'(4 * i);
                    r.errs = r.errs + 16'd1;
                end
            end
            if (r.errs != 16'd0) r.pass = 1'b0;
            r.cycles = 2 * int'(N) * (ws + 1) + 1;
        end
        res_q.push_back(r);
    endtask

    // Pulse start, optionally pulse it again mid-run, then wait for done and score the result.
    task automatic do_run(input string name, input int restart_at);
        res_t r;
        int   k;
        bit   seen;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({name, "_busy_entry"}, 32'(busy), 32'd1);
        check({name, "_done_clr"}, 32'(done), 32'd0);
        check({name, "_err_clr"}, 32'(err_count), 32'd0);
        seen = 1'b0;
        k = 0;
        while (!seen && k < LIMIT) begin
            start = (k == restart_at);
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            check({name, "_done_wait"}, 32'd0, 32'd1);
            return;
        end
        r = res_q.pop_front();
        check({name, "_cycles"}, 32'(k), 32'(r.cycles));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_pass"}, 32'(pass), 32'(r.pass));
        check({name, "_timeout"}, 32'(timeout), 32'(r.tmo));
        check({name, "_err_count"}, 32'(err_count), 32'(r.errs));
        check({name, "_first_err"}, first_err_adr, r.first);
        check({name, "_cyc_idle"}, 32'(bus.cyc), 32'd0);
        check({name, "_xfers_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit hit;
        for (int i = 0; i < int'(N); i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_first", first_err_adr, 32'd0);
        check("rst_cyc", 32'(bus.cyc), 32'd0);
        check("rst_stb", 32'(bus.stb), 32'd0);
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_adr", bus.adr, 32'd0);
        check("rst_dat", bus.dat_ms, 32'd0);
        check("static_sel", 32'(bus.sel), 32'hF);
        check("static_cti", 32'(bus.cti), 32'd0);
        check("static_bte", 32'(bus.bte), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait clean run.
        wait_states = 0;
        push_run(1'b0, 1'b0, 0, 0);
        do_run("zw", -1);

        // Two wait states, with a stray start pulse while writing.
        wait_states = 2;
        push_run(1'b0, 1'b0, 0, 2);
        do_run("ws2", 7);

        // Read data bit 3 stuck low.
        wait_states = 0;
        stuck3 = 1'b1;
        push_run(1'b1, 1'b0, 0, 0);
        do_run("stuck", -1);
        stuck3 = 1'b0;

        // Relaunch from DONE with errors pending: counters must clear on entry.
        push_run(1'b0, 1'b0, 0, 0);
        do_run("relaunch", -1);

        // Slave never acks 0x0C: watchdog abort.
        hang_en = 1'b1;
        push_run(1'b0, 1'b1, 3, 0);
        do_run("hang", -1);
        hang_en = 1'b0;

        // Reset in READ at index 5, then a clean run.
        push_run(1'b0, 1'b0, 0, 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < LIMIT && !hit; k++) begin
            if (bus.cyc && !bus.we && bus.adr == 32'h14) hit = 1'b1;
            else @(negedge clk);
        end
        check("rstmid_reach", 32'(hit), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_cyc", 32'(bus.cyc), 32'd0);
        check("rstmid_stb", 32'(bus.stb), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        exp_q.delete();
        res_q.delete();
        rst = 1'b0;
        @(negedge clk);
        push_run(1'b0, 1'b0, 0, 0);
        do_run("after_rst", -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
